hazard_scoreboard: RTL and testbench

//  Next-generation hazard unit for the 5-stage pipeline. It supports one variable-latency, non-pipelined long-op unit (mul/div).

---
 rtl/hazard_scoreboard.sv | 151 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard unit for the 5-stage pipeline with one variable-latency,
//   non-pipelined long-op unit (mul/div).
//   - E/D-stage forwarding selects (00 regfile, 01 from M, 10 from W).
//   - Load-use and branch-compare stalls.
//   - Per-register pending-write scoreboard for long-op results. It catches
//     RAW on rsD/rtD and WAW on rdD.
//   - Structural stall while the long-op unit is occupied.
//   - Saturating count of stalled decode cycles.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   rsD, rtD, rdD, regwriteD,    decode-stage fields
//   longopD, branchD
//   rsE, rtE, writeregE,         execute-stage fields
//   regwriteE, memtoregE, longopE
//   writeregM, regwriteM,        memory-stage fields
//   memtoregM
//   writeregW, regwriteW         writeback-stage fields
//   longdoneW, longregW          long-op unit writes back longregW this cycle
//   stallF, stallD, flushE       pipeline-register controls (all equal)
//   forwardAD/BD, forwardAE/BE   operand selects
//   busy                         long-op unit occupied
//   stallcnt                     saturating count of cycles with stallD=1
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int NREG = 32,
   parameter int REGW = 5,
   parameter int LAT  = 4,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [REGW-1:0] rsD,
   input  logic [REGW-1:0] rtD,
   input  logic [REGW-1:0] rdD,
   input  logic            regwriteD,
   input  logic            longopD,
   input  logic            branchD,
   input  logic [REGW-1:0] rsE,
   input  logic [REGW-1:0] rtE,
   input  logic [REGW-1:0] writeregE,
   input  logic [REGW-1:0] writeregM,
   input  logic [REGW-1:0] writeregW,
   input  logic            regwriteE,
   input  logic            regwriteM,
   input  logic            regwriteW,
   input  logic            memtoregE,
   input  logic            memtoregM,
   input  logic            longopE,
   input  logic            longdoneW,
   input  logic [REGW-1:0] longregW,
   output logic            stallF,
   output logic            stallD,
   output logic            flushE,
   output logic [1:0]      forwardAD,
   output logic [1:0]      forwardBD,
   output logic [1:0]      forwardAE,
   output logic [1:0]      forwardBE,
   output logic            busy,
   output logic [CNTW-1:0] stallcnt
);

   localparam int CW = $clog2(LAT + 1);

   logic [NREG-1:0] sb_q, sb_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            valid_e_q, valid_e_d;
   logic [CNTW-1:0] stallcnt_q, stallcnt_d;

   logic issue_e, set_e;
   logic lwstall, brstall, sbstall, structstall, stall;

   // M has priority over W; register 0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src,
                                          input logic [REGW-1:0] wm, input logic rwm,
                                          input logic [REGW-1:0] ww, input logic rww);
      if (src == '0)              return 2'b00;
      else if (rwm && (wm == src)) return 2'b01;
      else if (rww && (ww == src)) return 2'b10;
      else                        return 2'b00;
   endfunction

   // A source/dest is blocked if its result is outstanding, including a long
   // op issuing this very cycle (its sb bit is not visible until the edge).
   function automatic logic pending(input logic [REGW-1:0] r, input logic [NREG-1:0] sb,
                                    input logic set, input logic [REGW-1:0] we);
      return (r != '0) && (sb[r] || (set && (r == we)));
   endfunction

   always_comb begin
      forwardAD = fwd_sel(rsD, writeregM, regwriteM, writeregW, regwriteW);
      forwardBD = fwd_sel(rtD, writeregM, regwriteM, writeregW, regwriteW);
      forwardAE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
      forwardBE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);

      // The E instruction was admitted from D last cycle, so its validity is a
      // registered fact; using it (not this cycle's flushE) avoids a comb loop.
      issue_e = longopE & valid_e_q;
      set_e   = issue_e & regwriteE & (writeregE != '0);

      lwstall = memtoregE & (writeregE != '0) &
                ((rsD == writeregE) | (rtD == writeregE));
      brstall = branchD &
                ((regwriteE & (writeregE != '0) & ((rsD == writeregE) | (rtD == writeregE))) |
                 (memtoregM & (writeregM != '0) & ((rsD == writeregM) | (rtD == writeregM))));
      sbstall = pending(rsD, sb_q, set_e, writeregE) |
                pending(rtD, sb_q, set_e, writeregE) |
                (regwriteD & pending(rdD, sb_q, set_e, writeregE));
      busy        = (cnt_q != '0);
      structstall = longopD & (busy | issue_e);
      stall       = lwstall | brstall | sbstall | structstall;

      // Clear first so that a same-cycle set on the same register wins.
      sb_d = sb_q;
      if (longdoneW) sb_d[longregW] = 1'b0;
      if (set_e)     sb_d[writeregE] = 1'b1;
      sb_d[0] = 1'b0;

      if (issue_e)            cnt_d = CW'(LAT);
      else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
      else                    cnt_d = cnt_q;

      // A flush bubbles E, so next cycle's E slot holds nothing valid.
      valid_e_d = ~stall;

      if (stall && (stallcnt_q != '1)) stallcnt_d = stallcnt_q + CNTW'(1);
      else                             stallcnt_d = stallcnt_q;
   end

   assign stallF   = stall;
   assign stallD   = stall;
   assign flushE   = stall;
   assign stallcnt = stallcnt_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sb_q       <= '0;
         cnt_q      <= '0;
         valid_e_q  <= 1'b0;
         stallcnt_q <= '0;
      end else begin
         sb_q       <= sb_d;
         cnt_q      <= cnt_d;
         valid_e_q  <= valid_e_d;
         stallcnt_q <= stallcnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random stimulus, all
// checked against a reference model that tracks pending registers as a bit
// array and long-op occupancy as a cycle window after the last issue.
module tb_hazard_scoreboard;

   localparam int NREG = 32;
   localparam int REGW = 5;
   localparam int LAT  = 4;
   localparam int CNTW = 16;
   localparam int EXPW = 1 + 8 + 1 + CNTW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            resetn;
   logic [REGW-1:0] rsD, rtD, rdD, rsE, rtE, writeregE, writeregM, writeregW, longregW;
   logic            regwriteD, longopD, branchD, regwriteE, regwriteM, regwriteW;
   logic            memtoregE, memtoregM, longopE, longdoneW;
   logic            stallF, stallD, flushE, busy;
   logic [1:0]      forwardAD, forwardBD, forwardAE, forwardBE;
   logic [CNTW-1:0] stallcnt;

   hazard_scoreboard #(.NREG(NREG), .REGW(REGW), .LAT(LAT), .CNTW(CNTW)) dut (
      .clk(clk), .resetn(resetn),
      .rsD(rsD), .rtD(rtD), .rdD(rdD), .regwriteD(regwriteD), .longopD(longopD), .branchD(branchD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
      .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
      .memtoregE(memtoregE), .memtoregM(memtoregM), .longopE(longopE),
      .longdoneW(longdoneW), .longregW(longregW),
      .stallF(stallF), .stallD(stallD), .flushE(flushE),
      .forwardAD(forwardAD), .forwardBD(forwardBD), .forwardAE(forwardAE), .forwardBE(forwardBE),
      .busy(busy), .stallcnt(stallcnt)
   );

   // ---------------- scoreboard ----------------
   logic [EXPW-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit              pend[NREG];
   bit              e_valid;
   bit              have_issue;
   int              last_issue;
   int              cyc_n;
   logic [CNTW-1:0] m_stallcnt;
   bit              exp_stall_cur;

   function automatic logic [1:0] m_fwd(input logic [REGW-1:0] s);
      if (s == 0) return 2'b00;
      if (regwriteM && writeregM == s) return 2'b01;
      if (regwriteW && writeregW == s) return 2'b10;
      return 2'b00;
   endfunction

   // Unit is occupied in the LAT cycles following the most recent issue.
   function automatic bit m_busy();
      return have_issue && (cyc_n > last_issue) && (cyc_n <= last_issue + LAT);
   endfunction

   function automatic bit m_blocked(input logic [REGW-1:0] r);
      bit issuing_to;
      issuing_to = longopE && e_valid && regwriteE && (writeregE != 0) && (r == writeregE);
      return (r != 0) && (pend[r] || issuing_to);
   endfunction

   task automatic push_expect();
      bit lw, br, sb, st, s;
      lw = memtoregE && (writeregE != 0) && (rsD == writeregE || rtD == writeregE);
      br = branchD && ((regwriteE && writeregE != 0 && (rsD == writeregE || rtD == writeregE)) ||
                       (memtoregM && writeregM != 0 && (rsD == writeregM || rtD == writeregM)));
      sb = m_blocked(rsD) || m_blocked(rtD) || (regwriteD && m_blocked(rdD));
      st = longopD && (m_busy() || (longopE && e_valid));
      s  = lw || br || sb || st;
      exp_stall_cur = s;
      exp_q.push_back({s, m_fwd(rsD), m_fwd(rtD), m_fwd(rsE), m_fwd(rtE), m_busy(), m_stallcnt});
   endtask

   task automatic model_edge();
      bit issue;
      if (!resetn) begin
         foreach (pend[i]) pend[i] = 1'b0;
         e_valid    = 1'b0;
         have_issue = 1'b0;
         m_stallcnt = '0;
      end else begin
         issue = longopE && e_valid;
         if (longdoneW) pend[longregW] = 1'b0;
         if (issue && regwriteE && writeregE != 0) pend[writeregE] = 1'b1;
         if (issue) begin
            have_issue = 1'b1;
            last_issue = cyc_n;
         end
         if (exp_stall_cur && m_stallcnt != {CNTW{1'b1}}) m_stallcnt = m_stallcnt + 1'b1;
         e_valid = !exp_stall_cur;
      end
      cyc_n++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      resetn = 1'b1;
      {rsD, rtD, rdD, rsE, rtE, writeregE, writeregM, writeregW, longregW} = '0;
      {regwriteD, longopD, branchD, regwriteE, regwriteM, regwriteW} = '0;
      {memtoregE, memtoregM, longopE, longdoneW} = '0;
   endtask

   // Inputs are already applied; record expectation and settle combinational outputs.
   task automatic start_cycle();
      push_expect();
      #1;
   endtask

   task automatic end_cycle();
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic idle_cycle();
      set_idle();
      start_cycle();
      end_cycle();
   endtask

   task automatic rand_inputs();
      resetn    = ($urandom_range(0, 99) != 0);
      rsD       = REGW'($urandom_range(0, 7));
      rtD       = REGW'($urandom_range(0, 7));
      rdD       = REGW'($urandom_range(0, 7));
      rsE       = REGW'($urandom_range(0, 7));
      rtE       = REGW'($urandom_range(0, 7));
      writeregE = REGW'($urandom_range(0, 7));
      writeregM = REGW'($urandom_range(0, 7));
      writeregW = REGW'($urandom_range(0, 7));
      longregW  = REGW'($urandom_range(0, 7));
      regwriteD = ($urandom_range(0, 1) == 0);
      regwriteE = ($urandom_range(0, 1) == 0);
      regwriteM = ($urandom_range(0, 1) == 0);
      regwriteW = ($urandom_range(0, 1) == 0);
      longopD   = ($urandom_range(0, 3) == 0);
      branchD   = ($urandom_range(0, 3) == 0);
      memtoregE = ($urandom_range(0, 5) == 0);
      memtoregM = ($urandom_range(0, 5) == 0);
      longopE   = ($urandom_range(0, 2) == 0);
      longdoneW = ($urandom_range(0, 1) == 0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [EXPW-1:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall_flush", {29'd0, stallF, stallD, flushE}, {29'd0, {3{e[EXPW-1]}}});
            chk("forwards", {24'd0, forwardAD, forwardBD, forwardAE, forwardBE}, {24'd0, e[EXPW-2 -: 8]});
            chk("busy", {31'd0, busy}, {31'd0, e[CNTW]});
            chk("stallcnt", {16'd0, stallcnt}, {16'd0, e[CNTW-1:0]});
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      cyc_n = 0;
      exp_stall_cur = 1'b0;
      set_idle();
      resetn = 1'b0;
      @(posedge clk);
      #1;
      model_edge();

      // Load-use: lw x7 in E, consumer reads x7 in D.
      set_idle();
      memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd7; rtD = 5'd7;
      start_cycle();
      chk("lw_stall", {31'd0, stallD}, 32'd1);
      chk("lw_cnt_before", {16'd0, stallcnt}, 32'd0);
      end_cycle();
      set_idle();
      start_cycle();
      chk("lw_cnt_after", {16'd0, stallcnt}, 32'd1);
      chk("lw_released", {31'd0, stallD}, 32'd0);
      end_cycle();

      // Forwarding: x5 in both M and W, M wins; index 0 never forwards.
      set_idle();
      regwriteM = 1'b1; writeregM = 5'd5; regwriteW = 1'b1; writeregW = 5'd5; rsE = 5'd5;
      start_cycle();
      chk("fwdAE_m_prio", {30'd0, forwardAE}, 32'd1);
      end_cycle();
      rsE = 5'd0;
      start_cycle();
      chk("fwdAE_zero", {30'd0, forwardAE}, 32'd0);
      end_cycle();

      // RAW on a long-op result: div x9 issuing, consumer of x9 in D.
      idle_cycle();
      set_idle();
      longopE = 1'b1; regwriteE = 1'b1; writeregE = 5'd9; rsD = 5'd9;
      start_cycle();
      chk("raw_bypass", {31'd0, stallD}, 32'd1);
      end_cycle();
      for (int i = 0; i < 3; i++) begin
         set_idle();
         rsD = 5'd9;
         start_cycle();
         chk("raw_pending", {31'd0, stallD}, 32'd1);
         end_cycle();
      end
      longdoneW = 1'b1; longregW = 5'd9;
      start_cycle();
      chk("raw_done_cycle", {31'd0, stallD}, 32'd1);
      end_cycle();
      longdoneW = 1'b0;
      start_cycle();
      chk("raw_cleared", {31'd0, stallD}, 32'd0);
      end_cycle();

      // Same-cycle set and clear of x3: set wins.
      set_idle();
      longopE = 1'b1; regwriteE = 1'b1; writeregE = 5'd3; longdoneW = 1'b1; longregW = 5'd3;
      start_cycle();
      end_cycle();
      set_idle();
      rtD = 5'd3;
      start_cycle();
      chk("set_wins", {31'd0, stallD}, 32'd1);
      end_cycle();
      set_idle();
      longdoneW = 1'b1; longregW = 5'd3;
      start_cycle();
      end_cycle();

      // Structural stall: long op issues while another long op waits in D.
      set_idle();
      longopE = 1'b1; regwriteE = 1'b1; writeregE = 5'd10; longopD = 1'b1;
      start_cycle();
      chk("struct_issue", {31'd0, stallD}, 32'd1);
      end_cycle();
      for (int i = 0; i < LAT + 1; i++) begin
         set_idle();
         longopD = 1'b1;
         start_cycle();
         end_cycle();
      end
      set_idle();
      longdoneW = 1'b1; longregW = 5'd10;
      start_cycle();
      end_cycle();

      // Reset in the middle of a long op to x4.
      idle_cycle();
      set_idle();
      longopE = 1'b1; regwriteE = 1'b1; writeregE = 5'd4;
      start_cycle();
      end_cycle();
      idle_cycle();
      idle_cycle();
      set_idle();
      resetn = 1'b0;
      start_cycle();
      end_cycle();
      set_idle();
      rsD = 5'd4;
      start_cycle();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_sb", {31'd0, stallD}, 32'd0);
      chk("rst_stallcnt", {16'd0, stallcnt}, 32'd0);
      end_cycle();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         start_cycle();
         end_cycle();
      end

      // Saturation: hold a load-use stall for longer than the counter range.
      set_idle();
      resetn = 1'b0;
      start_cycle();
      end_cycle();
      set_idle();
      memtoregE = 1'b1; writeregE = 5'd7; rtD = 5'd7;
      for (int i = 0; i < (1 << CNTW) + 5; i++) begin
         start_cycle();
         end_cycle();
      end
      start_cycle();
      chk("stallcnt_sat", {16'd0, stallcnt}, {16'd0, {CNTW{1'b1}}});
      end_cycle();

      set_idle();
      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
